txuart_arbiter: RTL and testbench
=================================

# txuart_arbiter

Round-robin, message-granular arbiter that shares one `txuart` transmitter among `NREQ` independent message sources, such as a periodic "Hello, World!" generator, a status reporter or a debug dumper. Each source streams bytes through its own stb/busy channel. Once a source is granted, it keeps the transmitter until it sends a byte flagged `last`, so messages never interleave. A one-entry output register drives `txuart`. An idle-timeout reclaims the grant from a source that stalls mid-message.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CLKS`, 1_200_000: clocks a granted source may hold `stb` low before its grant is revoked (0.1 s at 12 MHz). Must be in 1..2^24-1.
- `i_clk` in 1: system clock; all logic is on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_stb` in NREQ: per-source byte-valid.
- `i_req_data` in 8*NREQ: per-source byte; source i occupies bits [8i+7:8i].
- `i_req_last` in NREQ: the byte offered by source i ends its message.
- `o_req_busy` out NREQ: per-source stall. Source i's byte is accepted when `i_req_stb[i] && !o_req_busy[i]`.
- `o_tx_stb` out 1: byte request to `txuart`.
- `o_tx_data` out 8: byte to `txuart`.
- `i_tx_busy` in 1: `txuart` busy. The byte is taken when `o_tx_stb && !i_tx_busy`.
- `o_grant` out NREQ: one-hot current owner; all zeros when idle.
- `o_timeout` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- **Reset values:** state IDLE; `o_grant` = 0; `o_tx_stb` = 0; `o_tx_data` = 8'h00; `o_timeout` = 0; timeout counter = 0; last-winner pointer = NREQ-1, so source 0 has first priority.
- **State IDLE:**
  - If any `i_req_stb` bit is set, pick the first requesting index after the last winner, wrapping modulo NREQ.
  - Register that index into `o_grant` and the last-winner pointer, then go to LOCKED.
  - Arbitration looks only at `i_req_stb`. No bytes are accepted in IDLE.
- **Output register free condition:** `free = !o_tx_stb || !i_tx_busy`.
- **Stall equation:** `o_req_busy[i] = !(LOCKED && o_grant[i]) || !free`. Non-granted sources always see busy = 1.
- **Accept:** when the granted source's byte is accepted, load `o_tx_data` with it and set `o_tx_stb` = 1 on the next edge.
- **Drain:** if `o_tx_stb && !i_tx_busy` and no new byte is accepted that cycle, clear `o_tx_stb`.
- **Message end:** accepting a byte with `i_req_last[g]` = 1 returns the state to IDLE and clears `o_grant` on the next edge. Any byte already in the output register still drains normally.
- **Timeout counter:**
  - In LOCKED, it increments each cycle that `i_req_stb[g]` = 0 and resets to 0 each cycle it is 1.
  - When the counter equals TIMEOUT_CLKS-1 and `stb` is still low: go to IDLE, clear `o_grant`, pulse `o_timeout`, and clear the counter.
  - The last-winner pointer keeps the timed-out index, so that source drops to lowest priority.
- **Arithmetic:** the counter is 24 bits. It never wraps because it is cleared at the limit.
- **Simultaneous events:** a last-byte accept and a timeout match cannot coincide, since an accept requires `stb` = 1. The counter is ignored in the accept cycle.
- **Reset mid-message:**
  - Everything returns to reset values immediately, and the pending `o_tx_stb` byte is discarded.
  - `txuart` is not reset by this block; any character already shifting completes.
- **Source obligations:** keep `i_req_data`/`i_req_last` stable while `stb && busy`. The arbiter does not check this.

## Timing
- Request in IDLE at cycle t gives `o_grant` at t+1.
- The first byte is accepted at t+1 if the output register is free, and `o_tx_stb` rises at t+2.
- One byte per cycle is sustained when `i_tx_busy` is low. There is no bubble between consecutive bytes of one message.
- Between messages there is exactly one IDLE arbitration cycle. Last byte accepted at cycle u gives IDLE at u+1 and the next grant at u+2.
- All outputs are registered except `o_req_busy`, which is combinational from state, `o_tx_stb` and `i_tx_busy`.
- Timeout: grant is revoked TIMEOUT_CLKS cycles after the last cycle `stb` was high. `o_timeout` is high in the same cycle `o_grant` goes to 0.

## Test plan
- **Single source:**
  - Stimulus: source 0 sends "Hi\n" with `last` on '\n'; `i_tx_busy` tied 0.
  - Response: `o_tx_data` shows 0x48, 0x69, 0x0A on consecutive cycles starting 2 cycles after first `stb`; `o_grant` = 4'b0001, then 0 one cycle after the '\n' accept.
- **Round robin:**
  - Stimulus: sources 0, 1 and 3 request simultaneously from reset, each sending a 2-byte message.
  - Response: grant order 0, 1, 3, with one IDLE cycle between messages; no bytes interleaved.
- **Lockout:**
  - Stimulus: source 2 is mid-message while source 0 raises `stb`.
  - Response: `o_req_busy[0]` stays 1 until source 2's `last` byte is accepted; source 0 is then granted next.
- **Backpressure:**
  - Stimulus: `i_tx_busy` = 1 for 50 cycles with `o_tx_stb` = 1.
  - Response: `o_tx_data` holds its value; `o_req_busy` of the owner is 1; exactly one byte is taken when busy falls.
- **Timeout:**
  - Stimulus: TIMEOUT_CLKS = 8; source 1 sends one non-last byte, then drops `stb`.
  - Response: `o_timeout` pulses 8 cycles after `stb` falls, `o_grant` goes to 0, and waiting source 2 is granted next.
- **Reset mid-message:**
  - Stimulus: assert `i_reset` for 1 cycle with `o_tx_stb` = 1 and `i_tx_busy` = 1.
  - Response: the next cycle shows `o_tx_stb` = 0, `o_grant` = 0, and source 0 first in priority.

Source files
------------

// File: rtl/txuart_arbiter.sv
// Round-robin, message-granular arbiter sharing one txuart among NREQ byte
// sources; a source keeps the transmitter until its last byte or a stall timeout.
module txuart_arbiter #(
  parameter int NREQ         = 4,
  parameter int TIMEOUT_CLKS = 1_200_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_stb,
  input  logic [8*NREQ-1:0] i_req_data,
  input  logic [NREQ-1:0]   i_req_last,
  output logic [NREQ-1:0]   o_req_busy,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_timeout
);

  localparam int            PW            = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [23:0]   TIMEOUT_LIMIT = 24'(TIMEOUT_CLKS - 1);
  localparam logic [PW-1:0] LAST_INIT     = PW'(NREQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [PW-1:0]   last_winner;
  logic [23:0]     idle_count;

  logic            free;
  logic            locked;
  logic            grant_stb;
  logic            grant_last;
  logic            accept;
  logic            any_req;
  logic [7:0]      grant_data;
  logic [PW-1:0]   next_winner;
  logic [NREQ-1:0] next_grant;
  int              cand;

  assign free       = !o_tx_stb || !i_tx_busy;
  assign locked     = (state == LOCKED);
  assign grant_stb  = |(i_req_stb & o_grant);
  assign grant_last = |(i_req_last & o_grant);
  assign accept     = locked && grant_stb && free;
  assign any_req    = |i_req_stb;
  assign o_req_busy = ~(o_grant & {NREQ{locked}}) | {NREQ{!free}};
  assign next_grant = {{(NREQ-1){1'b0}}, 1'b1} << next_winner;

  always_comb begin
    grant_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (o_grant[i]) grant_data = grant_data | i_req_data[8*i +: 8];
    end
  end

  // Scan downward so the nearest requester after the last winner is written last and wins.
  always_comb begin
    cand        = 0;
    next_winner = last_winner;
    for (int k = NREQ; k >= 1; k--) begin
      cand = int'(last_winner) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (i_req_stb[cand[PW-1:0]]) next_winner = cand[PW-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      o_grant     <= '0;
      o_tx_stb    <= 1'b0;
      o_tx_data   <= 8'h00;
      o_timeout   <= 1'b0;
      idle_count  <= '0;
      last_winner <= LAST_INIT;
    end else begin
      o_timeout <= 1'b0;

      if (accept) begin
        o_tx_stb  <= 1'b1;
        o_tx_data <= grant_data;
      end else if (o_tx_stb && !i_tx_busy) begin
        o_tx_stb <= 1'b0;
      end

      case (state)
        IDLE: begin
          idle_count <= '0;
          if (any_req) begin
            o_grant     <= next_grant;
            last_winner <= next_winner;
            state       <= LOCKED;
          end
        end

        LOCKED: begin
          // The stall counter only runs while the owner has nothing to offer.
          if (grant_stb) begin
            idle_count <= '0;
            if (accept && grant_last) begin
              state   <= IDLE;
              o_grant <= '0;
            end
          end else if (idle_count == TIMEOUT_LIMIT) begin
            state      <= IDLE;
            o_grant    <= '0;
            o_timeout  <= 1'b1;
            idle_count <= '0;
          end else begin
            idle_count <= idle_count + 24'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_txuart_arbiter.sv
// Self-checking bench for txuart_arbiter: directed scenarios plus randomized
// traffic compared against a message-level reference model.
module tb_txuart_arbiter;

  localparam int NREQ         = 4;
  localparam int TIMEOUT_CLKS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_stb = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_busy;
  logic        tx_stb;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [3:0]  grant;
  logic        timeout;

  int compared = 0;
  int mismatched = 0;

  txuart_arbiter #(.NREQ(NREQ), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_req_stb  (req_stb),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_busy (req_busy),
    .o_tx_stb   (tx_stb),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy),
    .o_grant    (grant),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 when nobody holds the transmitter),
  // a one-byte output slot, and a run length of consecutive idle cycles.
  int         m_owner = -1;
  int         m_last_win = NREQ - 1;
  int         m_low_count = 0;
  int         m_acc_src = -1;
  logic       m_tx_stb = 1'b0;
  logic [7:0] m_tx_data = 8'h00;
  logic       m_timeout = 1'b0;
  bit         m_free;
  bit         m_found;
  int         m_cand;

  always @(posedge clk) begin
    m_acc_src = -1;
    if (reset) begin
      m_owner     = -1;
      m_last_win  = NREQ - 1;
      m_low_count = 0;
      m_tx_stb    = 1'b0;
      m_tx_data   = 8'h00;
      m_timeout   = 1'b0;
    end else begin
      m_free    = !m_tx_stb || !tx_busy;
      m_timeout = 1'b0;
      if (m_owner >= 0 && req_stb[m_owner[1:0]] && m_free) m_acc_src = m_owner;
      if (m_acc_src >= 0) begin
        m_tx_stb  = 1'b1;
        m_tx_data = 8'(req_data >> (8 * m_acc_src));
      end else if (m_tx_stb && !tx_busy) begin
        m_tx_stb = 1'b0;
      end
      if (m_owner < 0) begin
        m_low_count = 0;
        m_found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          m_cand = (m_last_win + k) % NREQ;
          if (!m_found && req_stb[m_cand[1:0]]) begin
            m_found    = 1'b1;
            m_owner    = m_cand;
            m_last_win = m_cand;
          end
        end
      end else if (m_acc_src >= 0) begin
        m_low_count = 0;
        if (req_last[m_owner[1:0]]) m_owner = -1;
      end else if (req_stb[m_owner[1:0]]) begin
        m_low_count = 0;
      end else begin
        m_low_count++;
        if (m_low_count == TIMEOUT_CLKS) begin
          m_owner     = -1;
          m_timeout   = 1'b1;
          m_low_count = 0;
        end
      end
    end
  end

  function automatic logic [3:0] model_grant();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  function automatic logic [3:0] model_busy();
    logic [3:0] b;
    for (int i = 0; i < NREQ; i++)
      b[i] = !(m_owner == i) || !(!m_tx_stb || !tx_busy);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    req_stb  = '0;
    req_last = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req_stb  = 4'($urandom);
    req_data = $urandom;
    req_last = 4'($urandom);
    tick();
    tick();
    reset   = 1'b0;
    req_stb = '0;
    @(negedge clk);
    compared++;
    if (grant !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
    compared++;
    if (tx_stb !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tx_stb: got %b want 0", tx_stb); end
    compared++;
    if (tx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
    compared++;
    if (timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout); end
    compared++;
    if (req_busy !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 1111", req_busy); end
    tick();
  endtask

  task automatic test_single_source();
    logic       stb_seq  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] data_seq [6] = '{8'h48, 8'h48, 8'h69, 8'h0A, 8'h00, 8'h00};
    logic       last_seq [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_grant[6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    logic       exp_stb  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_data [6] = '{8'h00, 8'h00, 8'h48, 8'h69, 8'h0A, 8'h00};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      req_stb  = {3'b000, stb_seq[c]};
      req_data = {24'h0, data_seq[c]};
      req_last = {3'b000, last_seq[c]};
      @(negedge clk);
      compared++;
      if (grant !== exp_grant[c]) begin mismatched++; $display("[TB] FAIL single_grant c%0d: got %b want %b", c, grant, exp_grant[c]); end
      compared++;
      if (req_busy !== ~exp_grant[c]) begin mismatched++; $display("[TB] FAIL single_busy c%0d: got %b want %b", c, req_busy, ~exp_grant[c]); end
      compared++;
      if (tx_stb !== exp_stb[c]) begin mismatched++; $display("[TB] FAIL single_tx_stb c%0d: got %b want %b", c, tx_stb, exp_stb[c]); end
      if (exp_stb[c]) begin
        compared++;
        if (tx_data !== exp_data[c]) begin mismatched++; $display("[TB] FAIL single_tx_data c%0d: got %h want %h", c, tx_data, exp_data[c]); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grant[11] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0};
    logic [7:0] exp_out  [6]  = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h31, 8'h32};
    int         ptr[4] = '{0, 0, 2, 0};
    logic [3:0] taken;
    logic [7:0] out_q[$];
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_stb[i]          = (ptr[i] < 2);
        req_data[8*i +: 8]  = 8'(16 * i + ptr[i] + 1);
        req_last[i]         = (ptr[i] == 1);
      end
      @(negedge clk);
      compared++;
      if (grant !== exp_grant[c]) begin mismatched++; $display("[TB] FAIL rr_grant c%0d: got %b want %b", c, grant, exp_grant[c]); end
      if (tx_stb && !tx_busy) out_q.push_back(tx_data);
      taken = req_stb & ~req_busy;
      tick();
      for (int i = 0; i < NREQ; i++) if (taken[i]) ptr[i]++;
    end
    req_stb = '0;
    compared++;
    if (out_q.size() != 6) begin
      mismatched++;
      $display("[TB] FAIL rr_byte_count: got %0d want 6", out_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        compared++;
        if (out_q[k] !== exp_out[k]) begin mismatched++; $display("[TB] FAIL rr_byte%0d: got %h want %h", k, out_q[k], exp_out[k]); end
      end
    end
  endtask

  task automatic test_lockout();
    logic [3:0] stb_seq  [8] = '{4'b0100, 4'b0100, 4'b0101, 4'b0001, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
    logic [7:0] d2_seq   [8] = '{8'h21, 8'h21, 8'h22, 8'h22, 8'h23, 8'h23, 8'h23, 8'h23};
    logic [3:0] last_seq [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
    logic [3:0] exp_grant[8] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1, 4'h0};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      req_stb  = stb_seq[c];
      req_data = {8'h00, d2_seq[c], 8'h00, 8'h30};
      req_last = last_seq[c];
      @(negedge clk);
      compared++;
      if (grant !== exp_grant[c]) begin mismatched++; $display("[TB] FAIL lock_grant c%0d: got %b want %b", c, grant, exp_grant[c]); end
      compared++;
      if (req_busy !== ~exp_grant[c]) begin mismatched++; $display("[TB] FAIL lock_busy c%0d: got %b want %b", c, req_busy, ~exp_grant[c]); end
      if (c == 7) begin
        compared++;
        if (tx_data !== 8'h30 || tx_stb !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_src0_byte: got stb=%b data=%h want stb=1 data=30", tx_stb, tx_data); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int taken = 0;
    apply_reset();
    req_stb  = 4'b0010;
    req_data = {16'h0, 8'hA1, 8'h00};
    tick();
    tick();
    req_data = {16'h0, 8'hA2, 8'h00};
    tx_busy  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      compared++;
      if (tx_stb !== 1'b1 || tx_data !== 8'hA1) begin mismatched++; $display("[TB] FAIL bp_hold c%0d: got stb=%b data=%h want stb=1 data=a1", c, tx_stb, tx_data); end
      compared++;
      if (req_busy !== 4'b1111) begin mismatched++; $display("[TB] FAIL bp_busy c%0d: got %b want 1111", c, req_busy); end
      if (tx_stb && !tx_busy) taken++;
      tick();
    end
    tx_busy = 1'b0;
    @(negedge clk);
    compared++;
    if (req_busy !== 4'b1101) begin mismatched++; $display("[TB] FAIL bp_release_busy: got %b want 1101", req_busy); end
    if (tx_stb && !tx_busy) taken++;
    tick();
    tx_busy = 1'b1;
    req_stb = 4'b0000;
    @(negedge clk);
    if (tx_stb && !tx_busy) taken++;
    compared++;
    if (taken != 1) begin mismatched++; $display("[TB] FAIL bp_taken: got %0d want 1", taken); end
    compared++;
    if (tx_stb !== 1'b1 || tx_data !== 8'hA2) begin mismatched++; $display("[TB] FAIL bp_next_byte: got stb=%b data=%h want stb=1 data=a2", tx_stb, tx_data); end
    tick();
    tx_busy = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    req_stb  = 4'b0010;
    req_data = {8'h00, 8'h66, 8'h55, 8'h00};
    req_last = 4'b0100;
    tick();
    @(negedge clk);
    compared++;
    if (grant !== 4'b0010) begin mismatched++; $display("[TB] FAIL to_first_grant: got %b want 0010", grant); end
    tick();
    req_stb = 4'b0100;
    for (int c = 0; c < TIMEOUT_CLKS; c++) begin
      @(negedge clk);
      compared++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL to_hold c%0d: got grant=%b to=%b want grant=0010 to=0", c, grant, timeout); end
      tick();
    end
    @(negedge clk);
    compared++;
    if (timeout !== 1'b1 || grant !== 4'b0000) begin mismatched++; $display("[TB] FAIL to_pulse: got to=%b grant=%b want to=1 grant=0000", timeout, grant); end
    tick();
    @(negedge clk);
    compared++;
    if (timeout !== 1'b0 || grant !== 4'b0100) begin mismatched++; $display("[TB] FAIL to_next_grant: got to=%b grant=%b want to=0 grant=0100", timeout, grant); end
    tick();
    req_stb = '0;
  endtask

  task automatic test_reset_mid_message();
    apply_reset();
    req_stb  = 4'b0001;
    req_data = {24'h0, 8'h77};
    tick();
    tick();
    req_data = {24'h0, 8'h78};
    tx_busy  = 1'b1;
    @(negedge clk);
    compared++;
    if (tx_stb !== 1'b1 || grant !== 4'b0001) begin mismatched++; $display("[TB] FAIL rst_pre: got stb=%b grant=%b want stb=1 grant=0001", tx_stb, grant); end
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    req_stb = 4'b0011;
    @(negedge clk);
    compared++;
    if (tx_stb !== 1'b0 || grant !== 4'b0000 || tx_data !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL rst_clear: got stb=%b grant=%b data=%h want stb=0 grant=0000 data=00", tx_stb, grant, tx_data);
    end
    tick();
    @(negedge clk);
    compared++;
    if (grant !== 4'b0001) begin mismatched++; $display("[TB] FAIL rst_priority: got %b want 0001", grant); end
    tick();
    req_stb = '0;
    tx_busy = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] cur_data[4];
    logic       cur_last[4];
    int         gap[4];
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      cur_data[i] = 8'($urandom);
      cur_last[i] = ($urandom_range(0, 3) == 0);
      gap[i]      = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gap[i] > 0) begin
          req_stb[i] = 1'b0;
          gap[i]--;
        end else if ($urandom_range(0, 39) == 0) begin
          req_stb[i] = 1'b0;
          gap[i]     = int'($urandom_range(4, 12));
        end else begin
          req_stb[i] = ($urandom_range(0, 4) != 0);
        end
        req_data[8*i +: 8] = cur_data[i];
        req_last[i]        = cur_last[i];
      end
      tx_busy = ($urandom_range(0, 2) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      compared++;
      if (grant !== model_grant()) begin mismatched++; $display("[TB] FAIL rnd_grant c%0d: got %b want %b", c, grant, model_grant()); end
      compared++;
      if (tx_stb !== m_tx_stb) begin mismatched++; $display("[TB] FAIL rnd_tx_stb c%0d: got %b want %b", c, tx_stb, m_tx_stb); end
      compared++;
      if (tx_data !== m_tx_data) begin mismatched++; $display("[TB] FAIL rnd_tx_data c%0d: got %h want %h", c, tx_data, m_tx_data); end
      compared++;
      if (timeout !== m_timeout) begin mismatched++; $display("[TB] FAIL rnd_timeout c%0d: got %b want %b", c, timeout, m_timeout); end
      compared++;
      if (req_busy !== model_busy()) begin mismatched++; $display("[TB] FAIL rnd_busy c%0d: got %b want %b", c, req_busy, model_busy()); end
      tick();
      if (m_acc_src >= 0) begin
        cur_data[m_acc_src] = 8'($urandom);
        cur_last[m_acc_src] = ($urandom_range(0, 3) == 0);
      end
    end
    reset   = 1'b0;
    req_stb = '0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_single_source();
    test_round_robin();
    test_lockout();
    test_backpressure();
    test_timeout();
    test_reset_mid_message();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
